// File: rtl/sea_round_ctrl.sv
// Iterative SEA round controller: one (L,R,K) block in, NR rounds through the external round datapath, result out.
// Latency: out_valid rises NR cycles after the accept edge; minimum block period is NR+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready is high.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready, in_dec     input handshake and encrypt(0)/decrypt(1) select
//   in_l, in_r, in_k              48-bit left half, right half and key
//   out_valid/out_ready           output handshake
//   out_l, out_r                  48-bit result halves
//   rd_li, rd_ri, rd_ki, rd_dec   drive the combinational round datapath
//   rd_nli, rd_nri                round datapath results, registered each RUN cycle
//   rnd, busy                     current round index, high while rounds are running
//   abort                         only with SEA_CTRL_ABORT_EN defined: drops the block in RUN/DONE
//
// Optional feature macro: SEA_CTRL_ABORT_EN

module sea_round_ctrl #(
    parameter int NR   = 16,    // rounds, 1..255
    parameter int KROT = 8      // key rotate per round in bits, 0..47
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_dec,
    input  logic [47:0] in_l,
    input  logic [47:0] in_r,
    input  logic [47:0] in_k,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_l,
    output logic [47:0] out_r,
    output logic [47:0] rd_li,
    output logic [47:0] rd_ri,
    output logic [47:0] rd_ki,
    input  logic [47:0] rd_nli,
    input  logic [47:0] rd_nri,
    output logic        rd_dec,
    output logic [7:0]  rnd,
    output logic        busy
`ifdef SEA_CTRL_ABORT_EN
    ,
    input  logic        abort
`endif
);

    // Per-round key step, and the start offset for decrypt: decrypt walks
    // the encrypt key schedule backwards, so it starts at the key used by
    // the last encrypt round, rotl(K, KROT*(NR-1)).
    localparam int          KSTEP    = KROT % 48;
    localparam int          KDEC     = (KROT * (NR - 1)) % 48;
    localparam logic [7:0]  RND_LAST = 8'(NR - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [47:0] r_lreg;
    logic [47:0] r_rreg;
    logic [47:0] r_kreg;
    logic        r_dreg;
    logic [7:0]  r_rnd;

    logic        w_accept;
    logic        w_round;
    logic        w_abort;
    logic [47:0] w_k_init;
    logic [47:0] w_k_next;

    // Rotations via a doubled word so that a zero amount needs no special
    // case (a shift by the full width would otherwise be required).
    function automatic logic [47:0] rotl48(input logic [47:0] x, input int n);
        logic [95:0] w_dbl;
        w_dbl = {x, x} >> (48 - n);
        return w_dbl[47:0];
    endfunction

    function automatic logic [47:0] rotr48(input logic [47:0] x, input int n);
        logic [95:0] w_dbl;
        w_dbl = {x, x} >> n;
        return w_dbl[47:0];
    endfunction

`ifdef SEA_CTRL_ABORT_EN
    // Abort is meaningless with nothing in flight.
    assign w_abort = abort & (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_k_init = in_dec ? rotl48(in_k, KDEC) : in_k;
    assign w_k_next = r_dreg ? rotr48(r_kreg, KSTEP) : rotl48(r_kreg, KSTEP);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_round     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_round = 1'b1;
                if (r_rnd == RND_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Taking the result returns to IDLE only; a new block is
                // accepted no earlier than the following cycle.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort beats both round advance and the output handshake, and
        // leaves the L/R/K registers untouched.
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_round     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Block state: halves, key, direction and round counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lreg <= '0;
            r_rreg <= '0;
            r_kreg <= '0;
            r_dreg <= 1'b0;
            r_rnd  <= '0;
        end else if (w_accept) begin
            r_lreg <= in_l;
            r_rreg <= in_r;
            r_kreg <= w_k_init;
            r_dreg <= in_dec;
            r_rnd  <= '0;
        end else if (w_round) begin
            r_lreg <= rd_nli;
            r_rreg <= rd_nri;
            r_kreg <= w_k_next;
            // Counter stops on the last round index and holds it through
            // DONE and IDLE until the next accept.
            if (r_rnd != RND_LAST) begin
                r_rnd <= r_rnd + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: straight from registers in every state
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign out_l     = r_lreg;
    assign out_r     = r_rreg;
    assign rd_li     = r_lreg;
    assign rd_ri     = r_rreg;
    assign rd_ki     = r_kreg;
    assign rd_dec    = r_dreg;
    assign rnd       = r_rnd;

endmodule

// File: tb/tb_sea_round_ctrl.sv
// Directed bench for sea_round_ctrl with a small Feistel round standing in for sea_en/sea_de.
// Latency: checks out_valid NR edges after accept; result hold under out_ready low.
// Backpressure: in_valid offered while busy/DONE must be ignored.

module tb_sea_round_ctrl;

    localparam int NR   = 16;
    localparam int KROT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_dec = 1'b0;
    logic [47:0] in_l = '0;
    logic [47:0] in_r = '0;
    logic [47:0] in_k = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_l;
    logic [47:0] out_r;
    logic [47:0] rd_li;
    logic [47:0] rd_ri;
    logic [47:0] rd_ki;
    logic [47:0] rd_nli;
    logic [47:0] rd_nri;
    logic        rd_dec;
    logic [7:0]  rnd;
    logic        busy;
`ifdef SEA_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sea_round_ctrl #(.NR(NR), .KROT(KROT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_l      (in_l),
        .in_r      (in_r),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_r     (out_r),
        .rd_li     (rd_li),
        .rd_ri     (rd_ri),
        .rd_ki     (rd_ki),
        .rd_nli    (rd_nli),
        .rd_nri    (rd_nri),
        .rd_dec    (rd_dec),
        .rnd       (rnd),
        .busy      (busy)
`ifdef SEA_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    function automatic logic [47:0] tb_rotl(input logic [47:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (48 - n));
    endfunction

    // Round function: any function of (half, key) gives an invertible Feistel round.
    function automatic logic [47:0] f_fn(input logic [47:0] x, input logic [47:0] k);
        return tb_rotl(x ^ k, 7) + (x & k);
    endfunction

    // Encrypt: (L,R) -> (R, L^F(R,K)).  Decrypt: (L,R) -> (R^F(L,K), L).
    assign rd_nli = rd_dec ? (rd_ri ^ f_fn(rd_li, rd_ki)) : rd_ri;
    assign rd_nri = rd_dec ? rd_li : (rd_li ^ f_fn(rd_ri, rd_ki));

    task automatic model_enc(input logic [47:0] l, input logic [47:0] r, input logic [47:0] k,
                             output logic [47:0] ol, output logic [47:0] orr);
        logic [47:0] t;
        for (int i = 0; i < NR; i++) begin
            t = r;
            r = l ^ f_fn(r, tb_rotl(k, (KROT * i) % 48));
            l = t;
        end
        ol  = l;
        orr = r;
    endtask

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then offers one block over one edge.
    task automatic accept(input logic [47:0] l, input logic [47:0] r, input logic [47:0] k,
                          input logic d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("accept_timeout", 48'(in_ready), 48'd1);
        in_l = l; in_r = r; in_k = k; in_dec = d; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Steps until out_valid, returning the number of edges since accept (cyc starts at start).
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (!out_valid && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] ct_l, ct_r, ex_l, ex_r;
        int cyc;
        int n;

        // ---------------- reset state ----------------
        #12;
        check("rst_in_ready", 48'(in_ready), 48'd1);
        check("rst_out_valid", 48'(out_valid), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_rnd", 48'(rnd), 48'd0);
        check("rst_out_l", out_l, 48'd0);
        check("rst_rd_ki", rd_ki, 48'd0);
        check("rst_rd_dec", 48'(rd_dec), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- encrypt: key schedule, latency, hold ----------------
        accept(48'h111111111111, 48'h222222222222, 48'h0123456789AB, 1'b0);
        check("enc_busy", 48'(busy), 48'd1);
        check("enc_in_ready", 48'(in_ready), 48'd0);
        check("enc_rd_dec", 48'(rd_dec), 48'd0);
        check("enc_rnd0", 48'(rnd), 48'd0);
        check("enc_k0", rd_ki, 48'h0123456789AB);
        step();
        check("enc_rnd1", 48'(rnd), 48'd1);
        check("enc_k1", rd_ki, 48'h23456789AB01);
        step();
        check("enc_k2", rd_ki, 48'h456789AB0123);
        wait_done(2, cyc);
        check("enc_latency", 48'(cyc), 48'(NR));
        model_enc(48'h111111111111, 48'h222222222222, 48'h0123456789AB, ex_l, ex_r);
        check("enc_out_l", out_l, ex_l);
        check("enc_out_r", out_r, ex_r);
        ct_l = ex_l;
        ct_r = ex_r;
        // Hold result with out_ready low while a stray block is offered.
        in_l = 48'hDEADBEEF0000; in_k = 48'hFFFFFFFFFFFF; in_dec = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_out_valid", 48'(out_valid), 48'd1);
            check("hold_in_ready", 48'(in_ready), 48'd0);
            check("hold_out_l", out_l, ct_l);
            check("hold_out_r", out_r, ct_r);
        end
        take_result();
        in_valid = 1'b0;
        check("take_out_valid", 48'(out_valid), 48'd0);
        check("take_in_ready", 48'(in_ready), 48'd1);
        check("take_not_accepted", 48'(busy), 48'd0);

        // ---------------- decrypt round trip ----------------
        step();
        accept(ct_l, ct_r, 48'h0123456789AB, 1'b1);
        check("dec_rd_dec", 48'(rd_dec), 48'd1);
        check("dec_k0", rd_ki, 48'h6789AB012345);
        step();
        check("dec_k1", rd_ki, 48'h456789AB0123);
        n = 0;
        while (rnd != 8'(NR - 1) && n < 300) begin
            step();
            n++;
        end
        check("dec_rnd_last", 48'(rnd), 48'(NR - 1));
        check("dec_k15", rd_ki, 48'h0123456789AB);
        wait_done(0, cyc);
        check("dec_out_valid", 48'(out_valid), 48'd1);
        check("dec_out_l", out_l, 48'h111111111111);
        check("dec_out_r", out_r, 48'h222222222222);
        take_result();

        // ---------------- reset mid-RUN ----------------
        accept(48'h0F0F0F0F0F0F, 48'hF0F0F0F0F0F0, 48'h13579BDF2468, 1'b0);
        n = 0;
        while (rnd != 8'd5 && n < 50) begin
            step();
            n++;
        end
        check("mid_rnd5", 48'(rnd), 48'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 48'(out_valid), 48'd0);
        check("mid_rst_busy", 48'(busy), 48'd0);
        check("mid_rst_rnd", 48'(rnd), 48'd0);
        check("mid_rst_in_ready", 48'(in_ready), 48'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        accept(48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 48'hFEDCBA987654, 1'b0);
        wait_done(0, cyc);
        check("post_rst_latency", 48'(cyc), 48'(NR));
        model_enc(48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 48'hFEDCBA987654, ex_l, ex_r);
        check("post_rst_out_l", out_l, ex_l);
        check("post_rst_out_r", out_r, ex_r);
        take_result();

`ifdef SEA_CTRL_ABORT_EN
        // ---------------- abort in RUN ----------------
        accept(48'h111111111111, 48'h222222222222, 48'h0123456789AB, 1'b0);
        n = 0;
        while (rnd != 8'd3 && n < 50) begin
            step();
            n++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_ready", 48'(in_ready), 48'd1);
        check("abort_busy", 48'(busy), 48'd0);
        n = 0;
        for (int i = 0; i < NR + 2; i++) begin
            if (out_valid) n++;
            step();
        end
        check("abort_no_out_valid", 48'(n), 48'd0);

        // ---------------- abort with out_ready in DONE ----------------
        accept(48'h111111111111, 48'h222222222222, 48'h0123456789AB, 1'b0);
        wait_done(0, cyc);
        check("abort_done_reached", 48'(out_valid), 48'd1);
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_done_out_valid", 48'(out_valid), 48'd0);
        check("abort_done_in_ready", 48'(in_ready), 48'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
